// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU / M-extension op codes,
// the muldiv FSM states and the operand-forwarding select.
package exec_pkg;

    // IDEX_aluOP_2: coarse operation class
    localparam logic [1:0] OP2_ADD = 2'b00;
    localparam logic [1:0] OP2_IMM = 2'b01;
    localparam logic [1:0] OP2_ALU = 2'b10;
    localparam logic [1:0] OP2_MD  = 2'b11;

    // IDEX_aluOP = {funct7[5], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // M-extension funct3
    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

    typedef enum logic [1:0] {FWD_IDEX, FWD_EXMEM, FWD_MEMWB} fwd_sel_e;

    // EX/MEM wins over MEM/WB; loads in EX/MEM have no data yet; x0 never forwards.
    function automatic fwd_sel_e fwd_select(input logic [4:0] rs,
                                            input logic [4:0] ex_rd,
                                            input logic       ex_wb,
                                            input logic       ex_mr,
                                            input logic [4:0] wb_rd,
                                            input logic       wb_we);
        if (ex_wb && !ex_mr && (ex_rd != 5'd0) && (ex_rd == rs))
            return FWD_EXMEM;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return FWD_MEMWB;
        return FWD_IDEX;
    endfunction

endpackage

// File: rtl/execute_stage_muldiv.sv
// Iterative 32-iteration multiplier / restoring divider (module muldiv_unit).
// Only built when MULDIV_EN is defined. Works on operand magnitudes and
// fixes signs on the way out; divide-by-zero is handled as a special case.
`ifdef MULDIV_EN
module muldiv_unit
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    md_state_e   state, state_nxt;
    logic [4:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q, dvs, hi, lo;
    logic        neg_q, neg_r, b_zero;
    logic        a_sgn, b_sgn, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum, div_sh;
    logic        div_geq;
    logic [31:0] div_rem;
    logic [63:0] prod, prod_s;
    logic [31:0] quo, rem;

    // Operand signedness and magnitudes for the op being issued
    always_comb begin
        a_sgn = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
        b_sgn = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
        a_neg = a_sgn & a[31];
        b_neg = b_sgn & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
    end

    // One shift-add (mul) or restoring-subtract (div) step; lo holds multiplier / quotient
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : 33'd0);
        div_sh  = {hi, lo[31]};
        div_geq = div_sh >= {1'b0, dvs};
        div_rem = div_sh[31:0] - dvs;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nxt;
    end

    // FSM next state: 32 BUSY iterations, one DONE cycle
    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start) state_nxt = MD_BUSY;
            MD_BUSY: if (cnt == 5'd31) state_nxt = MD_DONE;
            MD_DONE: state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    // Operand latch at issue, then iterate; later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            dvs    <= '0;
            hi     <= '0;
            lo     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else if (state == MD_IDLE && start) begin
            cnt    <= '0;
            op_q   <= op;
            a_q    <= a;
            dvs    <= b_mag;
            hi     <= '0;
            lo     <= a_mag;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            b_zero <= (b == 32'd0);
        end else if (state == MD_BUSY) begin
            cnt <= cnt + 5'd1;
            if (op_q[2]) begin
                hi <= div_geq ? div_rem : div_sh[31:0];
                lo <= {lo[30:0], div_geq};
            end else begin
                hi <= mul_sum[32:1];
                lo <= {mul_sum[0], lo[31:1]};
            end
        end
    end

    // Sign fix-up and result select
    always_comb begin
        prod   = {hi, lo};
        prod_s = neg_q ? (64'd0 - prod) : prod;
        quo    = b_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - lo) : lo);
        rem    = b_zero ? a_q : (neg_r ? (32'd0 - hi) : hi);
        case (op_q)
            MD_MUL:                       result = prod_s[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_s[63:32];
            MD_DIV, MD_DIVU:              result = quo;
            default:                      result = rem;
        endcase
    end

    assign busy = (state == MD_BUSY);
    assign done = (state == MD_DONE);

endmodule
`endif

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Optional M-extension via MULDIV_EN (iterative muldiv_unit, stalls upstream);
// without it M ops return 0 in one cycle and EX_stall is tied low.
module execute_stage
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IDEX_rs1,
    input  logic [4:0]  IDEX_rs2,
    input  logic [4:0]  IDEX_rd,
    input  logic [31:0] IDEX_imm,
    input  logic [31:0] IDEX_read_data1,
    input  logic [31:0] IDEX_read_data2,
    input  logic        IDEX_WriteBack,
    input  logic        IDEX_MemoryRead,
    input  logic        IDEX_MemoryWrite,
    input  logic        IDEX_AluSrc,
    input  logic        IDEX_Execution,
    input  logic [3:0]  IDEX_aluOP,
    input  logic [1:0]  IDEX_aluOP_2,
    input  logic [4:0]  MEMWB_rd,
    input  logic        MEMWB_WriteBack,
    input  logic [31:0] MEMEX_WriteBack,
    output logic [31:0] EXMEM_alu_result,
    output logic [31:0] EXMEM_store_data,
    output logic [4:0]  EXMEM_rd,
    output logic        EXMEM_WriteBack,
    output logic        EXMEM_MemoryRead,
    output logic        EXMEM_MemoryWrite,
    output logic        EX_stall
);

    fwd_sel_e    sel_a, sel_b;
    logic [31:0] op_a, fwd_b, alu_b, alu_out, ex_result;
    logic [4:0]  shamt;

    // Forwarding muxes for both register operands
    always_comb begin
        sel_a = fwd_select(IDEX_rs1, EXMEM_rd, EXMEM_WriteBack, EXMEM_MemoryRead,
                           MEMWB_rd, MEMWB_WriteBack);
        sel_b = fwd_select(IDEX_rs2, EXMEM_rd, EXMEM_WriteBack, EXMEM_MemoryRead,
                           MEMWB_rd, MEMWB_WriteBack);
        case (sel_a)
            FWD_EXMEM: op_a = EXMEM_alu_result;
            FWD_MEMWB: op_a = MEMEX_WriteBack;
            default:   op_a = IDEX_read_data1;
        endcase
        case (sel_b)
            FWD_EXMEM: fwd_b = EXMEM_alu_result;
            FWD_MEMWB: fwd_b = MEMEX_WriteBack;
            default:   fwd_b = IDEX_read_data2;
        endcase
        alu_b = IDEX_AluSrc ? IDEX_imm : fwd_b;
    end

    // Integer ALU; funct7[5] with an immediate means ADDI, not SUB
    always_comb begin
        shamt = alu_b[4:0];
        case (IDEX_aluOP)
            ALU_ADD:  alu_out = op_a + alu_b;
            ALU_SUB:  alu_out = IDEX_AluSrc ? (op_a + alu_b) : (op_a - alu_b);
            ALU_SLL:  alu_out = op_a << shamt;
            ALU_SLT:  alu_out = {31'd0, $signed(op_a) < $signed(alu_b)};
            ALU_SLTU: alu_out = {31'd0, op_a < alu_b};
            ALU_XOR:  alu_out = op_a ^ alu_b;
            ALU_SRL:  alu_out = op_a >> shamt;
            ALU_SRA:  alu_out = 32'($signed(op_a) >>> shamt);
            ALU_OR:   alu_out = op_a | alu_b;
            ALU_AND:  alu_out = op_a & alu_b;
            default:  alu_out = op_a + alu_b;
        endcase
    end

`ifdef MULDIV_EN
    logic        md_start, md_busy, md_done;
    logic [31:0] md_result;

    assign md_start = IDEX_Execution && (IDEX_aluOP_2 == OP2_MD);

    muldiv_unit u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (IDEX_aluOP[2:0]),
        .a      (op_a),
        .b      (fwd_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // Stall from issue through the last BUSY cycle; DONE lets the result through
    assign EX_stall = md_busy || (md_start && !md_done);
`else
    assign EX_stall = 1'b0;
`endif

    // Result select by operation class
    always_comb begin
        case (IDEX_aluOP_2)
            OP2_ADD: ex_result = op_a + alu_b;
            OP2_IMM: ex_result = alu_b;
            OP2_ALU: ex_result = alu_out;
`ifdef MULDIV_EN
            default: ex_result = md_result;
`else
            default: ex_result = 32'd0;
`endif
        endcase
    end

    // EX/MEM register; bubbles only clear the control bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EXMEM_alu_result  <= '0;
            EXMEM_store_data  <= '0;
            EXMEM_rd          <= '0;
            EXMEM_WriteBack   <= 1'b0;
            EXMEM_MemoryRead  <= 1'b0;
            EXMEM_MemoryWrite <= 1'b0;
        end else if (!IDEX_Execution || EX_stall) begin
            EXMEM_WriteBack   <= 1'b0;
            EXMEM_MemoryRead  <= 1'b0;
            EXMEM_MemoryWrite <= 1'b0;
        end else begin
            EXMEM_alu_result  <= ex_result;
            EXMEM_store_data  <= fwd_b;
            EXMEM_rd          <= IDEX_rd;
            EXMEM_WriteBack   <= IDEX_WriteBack;
            EXMEM_MemoryRead  <= IDEX_MemoryRead;
            EXMEM_MemoryWrite <= IDEX_MemoryWrite;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus pushes expected EX/MEM
// contents, a negedge monitor pops and compares whenever EX/MEM carries
// an active instruction. M-extension vectors run when MULDIV_EN is defined.
module tb_execute_stage;

    logic        clk, rst;
    logic [4:0]  IDEX_rs1, IDEX_rs2, IDEX_rd;
    logic [31:0] IDEX_imm, IDEX_read_data1, IDEX_read_data2;
    logic        IDEX_WriteBack, IDEX_MemoryRead, IDEX_MemoryWrite, IDEX_AluSrc, IDEX_Execution;
    logic [3:0]  IDEX_aluOP;
    logic [1:0]  IDEX_aluOP_2;
    logic [4:0]  MEMWB_rd;
    logic        MEMWB_WriteBack;
    logic [31:0] MEMEX_WriteBack;
    logic [31:0] EXMEM_alu_result, EXMEM_store_data;
    logic [4:0]  EXMEM_rd;
    logic        EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite, EX_stall;

    typedef struct {
        logic [31:0] res;
        logic [31:0] st;
        logic [4:0]  rd;
        logic        wb, mr, mw;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   compared = 0;
    int   mismatched = 0;

    execute_stage dut (
        .clk(clk), .rst(rst),
        .IDEX_rs1(IDEX_rs1), .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd),
        .IDEX_imm(IDEX_imm), .IDEX_read_data1(IDEX_read_data1), .IDEX_read_data2(IDEX_read_data2),
        .IDEX_WriteBack(IDEX_WriteBack), .IDEX_MemoryRead(IDEX_MemoryRead),
        .IDEX_MemoryWrite(IDEX_MemoryWrite), .IDEX_AluSrc(IDEX_AluSrc),
        .IDEX_Execution(IDEX_Execution), .IDEX_aluOP(IDEX_aluOP), .IDEX_aluOP_2(IDEX_aluOP_2),
        .MEMWB_rd(MEMWB_rd), .MEMWB_WriteBack(MEMWB_WriteBack), .MEMEX_WriteBack(MEMEX_WriteBack),
        .EXMEM_alu_result(EXMEM_alu_result), .EXMEM_store_data(EXMEM_store_data),
        .EXMEM_rd(EXMEM_rd), .EXMEM_WriteBack(EXMEM_WriteBack),
        .EXMEM_MemoryRead(EXMEM_MemoryRead), .EXMEM_MemoryWrite(EXMEM_MemoryWrite),
        .EX_stall(EX_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic [1:0] op2, input logic [3:0] op, input logic src,
                         input logic wb, input logic mr, input logic mw, input logic ex);
        IDEX_rs1 = rs1; IDEX_rs2 = rs2; IDEX_rd = rd;
        IDEX_read_data1 = d1; IDEX_read_data2 = d2; IDEX_imm = imm;
        IDEX_aluOP_2 = op2; IDEX_aluOP = op; IDEX_AluSrc = src;
        IDEX_WriteBack = wb; IDEX_MemoryRead = mr; IDEX_MemoryWrite = mw;
        IDEX_Execution = ex;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] res, input logic [31:0] st,
                              input logic [4:0] rd, input logic wb, input logic mr, input logic mw);
        exp_t e;
        e.nm = nm; e.res = res; e.st = st; e.rd = rd; e.wb = wb; e.mr = mr; e.mw = mw;
        exp_q.push_back(e);
    endtask

    // Single-cycle instruction: drive, record expectation, advance one edge
    task automatic issue(input string nm, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [1:0] op2, input logic [3:0] op,
                         input logic src, input logic wb, input logic mr, input logic mw,
                         input logic [31:0] er, input logic [31:0] es);
        drive(rs1, rs2, rd, d1, d2, imm, op2, op, src, wb, mr, mw, 1'b1);
        expect_out(nm, er, es, rd, wb, mr, mw);
        @(posedge clk); #1;
    endtask

    // M-extension op; rs1=20, rs2=21, rd=14
    task automatic mdop(input string nm, input logic [2:0] f3, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] er, input logic perturb);
        int cnt;
        drive(5'd20, 5'd21, 5'd14, d1, d2, 32'd0, 2'b11, {1'b0, f3}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef MULDIV_EN
        expect_out(nm, er, d2, 5'd14, 1'b1, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!EX_stall) break;
            cnt++;
            if (perturb && i == 2) begin
                MEMWB_rd = 5'd20; MEMWB_WriteBack = 1'b1; MEMEX_WriteBack = 32'h0000_1234;
            end
        end
        check({nm, " stall cycles"}, 32'(cnt), 32'd33);
        MEMWB_WriteBack = 1'b0;
        @(posedge clk); #1;
        IDEX_Execution = 1'b0;
`else
        expect_out(nm, 32'd0, d2, 5'd14, 1'b1, 1'b0, 1'b0);
        cnt = 0;
        if (perturb) cnt = 1;
        @(negedge clk);
        check({nm, " stall"}, {31'd0, EX_stall}, 32'd0);
        @(posedge clk); #1;
        cnt = cnt + 0;
`endif
    endtask

    // Monitor: every active EX/MEM entry must match the next expectation
    always @(negedge clk) begin
        if (!rst && (EXMEM_WriteBack || EXMEM_MemoryRead || EXMEM_MemoryWrite)) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected output: res=%h rd=%0d wb=%b, none required",
                         EXMEM_alu_result, EXMEM_rd, EXMEM_WriteBack);
            end else begin
                mon_e = exp_q.pop_front();
                if (EXMEM_alu_result !== mon_e.res || EXMEM_store_data !== mon_e.st ||
                    EXMEM_rd !== mon_e.rd || EXMEM_WriteBack !== mon_e.wb ||
                    EXMEM_MemoryRead !== mon_e.mr || EXMEM_MemoryWrite !== mon_e.mw) begin
                    mismatched++;
                    $display("FAIL %s: got res=%h st=%h rd=%0d ctl=%b%b%b, required res=%h st=%h rd=%0d ctl=%b%b%b",
                             mon_e.nm, EXMEM_alu_result, EXMEM_store_data, EXMEM_rd,
                             EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite,
                             mon_e.res, mon_e.st, mon_e.rd, mon_e.wb, mon_e.mr, mon_e.mw);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        MEMWB_rd = '0; MEMWB_WriteBack = 1'b0; MEMEX_WriteBack = '0;
        drive('0, '0, '0, '0, '0, '0, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset alu_result", EXMEM_alu_result, 32'd0);
        check("reset store_data", EXMEM_store_data, 32'd0);
        check("reset rd", {27'd0, EXMEM_rd}, 32'd0);
        check("reset ctl", {29'd0, EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite}, 32'd0);
        check("reset stall", {31'd0, EX_stall}, 32'd0);
        rst = 1'b0;

        // name            rs1 rs2 rd  d1            d2            imm      op2    op      src wb mr mw  result        store
        issue("add rd5",   1,  2,  5,  32'd4,        32'd3,        32'd0,   2'b10, 4'b0000, 0, 1, 0, 0, 32'd7,        32'd3);
        issue("sub fwd",   5,  3,  7,  32'd999,      32'd3,        32'd0,   2'b10, 4'b1000, 0, 1, 0, 0, 32'd4,        32'd3);
        issue("li rd6",    0,  0,  6,  32'd0,        32'd0,        32'd10,  2'b01, 4'b0000, 1, 1, 0, 0, 32'd10,       32'd0);
        MEMWB_rd = 5'd6; MEMWB_WriteBack = 1'b1; MEMEX_WriteBack = 32'd20;
        issue("exmem prio",6,  4,  8,  32'd1,        32'd5,        32'd0,   2'b10, 4'b0000, 0, 1, 0, 0, 32'd15,       32'd5);
        issue("memwb fwd", 6,  4,  9,  32'd1,        32'd5,        32'd0,   2'b10, 4'b0000, 0, 1, 0, 0, 32'd25,       32'd5);
        MEMWB_WriteBack = 1'b0;
        issue("store",     1,  9,  0,  32'd100,      32'd0,        32'd16,  2'b00, 4'b0000, 1, 0, 0, 1, 32'd116,      32'd25);
        issue("load",      1,  2,  10, 32'd200,      32'd0,        32'd4,   2'b00, 4'b0000, 1, 1, 1, 0, 32'd204,      32'd0);
        issue("no ld fwd", 10, 2,  11, 32'd55,       32'd0,        32'd0,   2'b10, 4'b0000, 0, 1, 0, 0, 32'd55,       32'd0);
        issue("wr x0",     1,  2,  0,  32'd77,       32'd0,        32'd0,   2'b10, 4'b0000, 0, 1, 0, 0, 32'd77,       32'd0);
        MEMWB_rd = 5'd0; MEMWB_WriteBack = 1'b1; MEMEX_WriteBack = 32'd99;
        issue("rd x0",     0,  0,  12, 32'd0,        32'd0,        32'd0,   2'b10, 4'b0000, 0, 1, 0, 0, 32'd0,        32'd0);
        MEMWB_WriteBack = 1'b0;
        issue("sll",       20, 21, 13, 32'd1,        32'h55,       32'd36,  2'b10, 4'b0001, 1, 1, 0, 0, 32'd16,       32'h55);
        issue("slt",       20, 21, 13, 32'hFFFFFFFF, 32'd1,        32'd0,   2'b10, 4'b0010, 0, 1, 0, 0, 32'd1,        32'd1);
        issue("sltu",      20, 21, 13, 32'hFFFFFFFF, 32'd1,        32'd0,   2'b10, 4'b0011, 0, 1, 0, 0, 32'd0,        32'd1);
        issue("xor",       20, 21, 13, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,   2'b10, 4'b0100, 0, 1, 0, 0, 32'h0FF00FF0, 32'hFF00FF00);
        issue("srl",       20, 21, 13, 32'h80000000, 32'd4,        32'd0,   2'b10, 4'b0101, 0, 1, 0, 0, 32'h08000000, 32'd4);
        issue("srai",      20, 21, 13, 32'h80000000, 32'h55,       32'd4,   2'b10, 4'b1101, 1, 1, 0, 0, 32'hF8000000, 32'h55);
        issue("or",        20, 21, 13, 32'hF0,       32'h0F,       32'd0,   2'b10, 4'b0110, 0, 1, 0, 0, 32'hFF,       32'h0F);
        issue("and",       20, 21, 13, 32'hF0,       32'h3C,       32'd0,   2'b10, 4'b0111, 0, 1, 0, 0, 32'h30,       32'h3C);
        issue("sub imm",   20, 21, 13, 32'd10,       32'h55,       32'd3,   2'b10, 4'b1000, 1, 1, 0, 0, 32'd13,       32'h55);
        issue("sub wrap",  20, 21, 13, 32'd0,        32'd1,        32'd0,   2'b10, 4'b1000, 0, 1, 0, 0, 32'hFFFFFFFF, 32'd1);
        issue("add wrap",  20, 21, 13, 32'hFFFFFFFF, 32'd1,        32'd0,   2'b00, 4'b0000, 0, 1, 0, 0, 32'd0,        32'd1);

        // Bubble with all control bits requested: nothing may reach EX/MEM
        drive(5'd20, 5'd21, 5'd13, 32'd1, 32'd2, 32'd0, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("bubble ctl", {29'd0, EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite}, 32'd0);

        //   name        f3      d1            d2            result        perturb
        mdop("mul",      3'b000, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1);
        mdop("mulh",     3'b001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0);
        mdop("mulhsu",   3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0);
        mdop("mulhu",    3'b011, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0);
        mdop("div by 0", 3'b100, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0);
        mdop("rem by 0", 3'b110, 32'd7,        32'd0,        32'd7,        1'b0);
        mdop("div ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        mdop("divu",     3'b101, 32'd100,      32'd7,        32'd14,       1'b0);
        mdop("rem neg",  3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);

        // Asynchronous reset mid-operation, then a normal ADD
`ifdef MULDIV_EN
        drive(5'd20, 5'd21, 5'd14, 32'd3, 32'd5, 32'd0, 2'b11, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        repeat (11) @(negedge clk);
        check("stall before rst", {31'd0, EX_stall}, 32'd1);
`else
        issue("add pre-rst", 1, 2, 16, 32'd5, 32'd6, 32'd0, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd11, 32'd6);
        @(negedge clk);
`endif
        #1;
        rst = 1'b1;
        drive(5'd1, 5'd2, 5'd15, 32'd40, 32'd2, 32'd0, 2'b10, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        check("rst stall", {31'd0, EX_stall}, 32'd0);
        check("rst alu_result", EXMEM_alu_result, 32'd0);
        check("rst ctl", {29'd0, EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite}, 32'd0);
        #1;
        rst = 1'b0;
        expect_out("add post-rst", 32'd42, 32'd2, 5'd15, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("post-rst latency wb", {31'd0, EXMEM_WriteBack}, 32'd1);
        check("post-rst latency res", EXMEM_alu_result, 32'd42);

        IDEX_Execution = 1'b0;
        repeat (3) @(posedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The module SHALL have the following ports, in this order:
- clk  in  1  single clock, all state rising-edge.
- rst  in  1  asynchronous, active-high reset.
- IDEX_rs1, IDEX_rs2, IDEX_rd  in  5 each  register indices from ID/EX.
- IDEX_imm, IDEX_read_data1, IDEX_read_data2  in  32 each  immediate and register-file operands.
- IDEX_WriteBack, IDEX_MemoryRead, IDEX_MemoryWrite, IDEX_AluSrc  in  1 each  control bits.
- IDEX_Execution  in  1  instruction valid; 0 means bubble.
- IDEX_aluOP  in  4  {funct7[5], funct3}.
- IDEX_aluOP_2  in  2  00 add, 01 pass imm, 10 ALU per aluOP, 11 M-extension.
- MEMWB_rd  in  5  write-back destination.
- MEMWB_WriteBack  in  1  write-back enable.
- MEMEX_WriteBack  in  32  write-back data.
- EXMEM_alu_result, EXMEM_store_data  out  32 each  registered result and store data.
- EXMEM_rd  out  5  registered destination.
- EXMEM_WriteBack, EXMEM_MemoryRead, EXMEM_MemoryWrite  out  1 each  registered control.
- EX_stall  out  1  combinational; upstream holds PC, IF/ID and ID/EX while high.

Function
REQ-002 Operand forwarding, A from rs1, B from rs2:
- EX/MEM source when EXMEM_WriteBack=1, EXMEM_MemoryRead=0, EXMEM_rd!=0 and EXMEM_rd matches.
- Otherwise MEM/WB source (MEMEX_WriteBack) when MEMWB_WriteBack=1, MEMWB_rd!=0 and MEMWB_rd matches.
- Otherwise the ID/EX read data.
- EX/MEM has priority over MEM/WB.
REQ-003 ALU B SHALL be IDEX_imm when IDEX_AluSrc=1, else the forwarded rs2.
REQ-004 EXMEM_store_data SHALL always be the forwarded rs2, never the immediate.
REQ-005 For aluOP_2=10, the aluOP codes SHALL be:
- 0000 ADD; 1000 SUB (only when AluSrc=0, otherwise ADD).
- 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
- Shift amount is B[4:0]; arithmetic wraps modulo 2^32.
REQ-006 aluOP_2=00 SHALL compute A+B; aluOP_2=01 SHALL pass B.
REQ-007 Single-cycle ops SHALL be latched into EX/MEM at the next clk edge (1-cycle latency).
REQ-008 When IDEX_Execution=0, EX/MEM SHALL load a bubble: WriteBack, MemoryRead and MemoryWrite all 0, other fields don't-care.
REQ-009 M ops (aluOP_2=11) SHALL run in a muldiv FSM with states IDLE, BUSY, DONE:
- Valid M op in IDLE: operands latched, EX_stall=1 combinationally in that cycle, go to BUSY with counter=0.
- BUSY: one iteration per cycle; after counter=31 go to DONE.
- DONE: EX_stall=0, result captured into EX/MEM at the clock edge, return to IDLE.
- EX_stall is high for exactly 33 cycles; the result reaches EX/MEM 34 edges after issue.
REQ-010 While EX_stall=1, EX/MEM SHALL load a bubble every cycle.
REQ-011 Forwarding during BUSY SHALL NOT affect the latched operands.
REQ-012 aluOP[2:0] for M ops SHALL select MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-013 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder equal to the dividend.
REQ-014 DIV 0x80000000 / -1 SHALL give quotient 0x80000000 and remainder 0.

Reset
REQ-015 rst=1 SHALL asynchronously clear:
- all EXMEM_* outputs to 0;
- FSM to IDLE, counter to 0;
- EX_stall to 0 even mid-BUSY, with the in-flight M op discarded.

Configuration
REQ-016 With MULDIV_EN defined, REQ-009..014 SHALL apply.
REQ-017 Without MULDIV_EN:
- aluOP_2=11 SHALL produce result 0 with 1-cycle latency;
- the FSM SHALL be absent and EX_stall SHALL be tied to 0;
- control bits SHALL pass unchanged.

Structure
REQ-018 Package exec_pkg SHALL hold:
- aluOP and aluOP_2 encodings;
- FSM state encoding;
- forwarding-select encoding (ID/EX, EX/MEM, MEM/WB).
REQ-019 The iterative multiplier/divider SHALL be sub-module muldiv_unit (start/busy/done handshake); forwarding and ALU stay in execute_stage.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ADD, rd=5, then SUB reading rs1=5 back-to-back: SUB uses the EX/MEM value; with 7 and 3 the SUB result is 4.
- EX/MEM and MEM/WB both target rs1=6 with values 10 and 20: the EX/MEM value 10 is used.
- MUL 0xFFFFFFFF x 2 (MULDIV_EN): EX_stall high 33 cycles, then EXMEM_alu_result=0xFFFFFFFE with EXMEM_WriteBack=1.
- DIV 7/0 gives 0xFFFFFFFF; REM 7/0 gives 7; DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
- rst pulsed at BUSY counter=10: EX_stall=0 and EX/MEM cleared the same cycle; the next ADD completes in 1 cycle.
- SRA 0x80000000 by imm 4 (AluSrc=1, aluOP=1101) gives 0xF8000000; IDEX_Execution=0 gives EXMEM_WriteBack=0.
